// File: rtl/linear_pwm_rgb.sv
// ============================================================================
// Module      : linear_pwm_rgb
// Description : Linear six-phase rainbow fader driving a common RGB LED
//               through three period-shadowed PWM channels.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module linear_pwm_rgb #(
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] rgb
);

  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PWM_BITS-1:0] c_duty_max  = '1;
  localparam logic [STEP_W-1:0]   c_step_last = STEP_W'(STEP_CYCLES - 1);

  typedef enum logic [2:0] {
    PH0 = 3'd0,
    PH1 = 3'd1,
    PH2 = 3'd2,
    PH3 = 3'd3,
    PH4 = 3'd4,
    PH5 = 3'd5
  } phase_t;

  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [STEP_W-1:0]   r_step_cnt;
  phase_t              r_phase;
  logic [PWM_BITS-1:0] r_level;
  logic [PWM_BITS-1:0] r_shd_r, r_shd_g, r_shd_b;

  logic                w_tick;
  logic                w_period_end;
  logic [PWM_BITS-1:0] w_down;
  logic [PWM_BITS-1:0] w_tgt_r, w_tgt_g, w_tgt_b;

  assign w_tick       = (r_step_cnt == c_step_last);
  assign w_period_end = (r_pwm_cnt == c_duty_max);
  assign w_down       = c_duty_max - r_level;

  // Each phase ramps exactly one channel; the other two sit at full or zero.
  always_comb begin
    w_tgt_r = '0;
    w_tgt_g = '0;
    w_tgt_b = '0;
    case (r_phase)
      PH0: begin w_tgt_r = c_duty_max; w_tgt_g = r_level;    end
      PH1: begin w_tgt_r = w_down;     w_tgt_g = c_duty_max; end
      PH2: begin w_tgt_g = c_duty_max; w_tgt_b = r_level;    end
      PH3: begin w_tgt_g = w_down;     w_tgt_b = c_duty_max; end
      PH4: begin w_tgt_r = r_level;    w_tgt_b = c_duty_max; end
      PH5: begin w_tgt_r = c_duty_max; w_tgt_b = w_down;     end
      default: begin end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pwm_cnt  <= '0;
      r_step_cnt <= '0;
      r_phase    <= PH0;
      r_level    <= '0;
      r_shd_r    <= c_duty_max;
      r_shd_g    <= '0;
      r_shd_b    <= '0;
      rgb        <= 3'b000;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;

      if (w_tick) begin
        r_step_cnt <= '0;
        if (r_level != c_duty_max) begin
          r_level <= r_level + 1'b1;
        end else begin
          r_level <= '0;
          r_phase <= (r_phase == PH5) ? PH0 : phase_t'(r_phase + 3'd1);
        end
      end else begin
        r_step_cnt <= r_step_cnt + 1'b1;
      end

      // Duties only change at the period boundary so a pulse is never cut.
      if (w_period_end) begin
        r_shd_r <= w_tgt_r;
        r_shd_g <= w_tgt_g;
        r_shd_b <= w_tgt_b;
      end

      rgb <= {(r_pwm_cnt < r_shd_r), (r_pwm_cnt < r_shd_g), (r_pwm_cnt < r_shd_b)};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_linear_pwm_rgb.sv
// ============================================================================
// Module      : tb_linear_pwm_rgb
// Description : Scoreboard bench for linear_pwm_rgb: per-period high times
//               and pulse contiguity against a closed-form colour-wheel model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_linear_pwm_rgb;

  localparam int c_step = 3;
  localparam int c_nper = 40;   // a bit over two full wheels (18 periods each)

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] rgb;

  always #5 clk = ~clk;

  linear_pwm_rgb #(
    .PWM_BITS    (8),
    .STEP_CYCLES (c_step)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rgb   (rgb)
  );

  typedef struct {
    int r;
    int g;
    int b;
  } duty_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  duty_t exp_q[$];
  bit    mon_en   = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Duty seen in period m after release: period 0 uses the reset shadow,
  // later periods use the target latched at edge 256*m, i.e. the state
  // after 256*m-1 edges, which have produced floor(n/STEP) ticks.
  function automatic duty_t model(input int m);
    duty_t d;
    int n, t, p, l, dn;
    d.r = 255; d.g = 0; d.b = 0;
    if (m > 0) begin
      n  = 256 * m - 1;
      t  = (n / c_step) % 1536;
      p  = t / 256;
      l  = t % 256;
      dn = 255 - l;
      case (p)
        0: begin d.r = 255; d.g = l;   d.b = 0;   end
        1: begin d.r = dn;  d.g = 255; d.b = 0;   end
        2: begin d.r = 0;   d.g = 255; d.b = l;   end
        3: begin d.r = 0;   d.g = dn;  d.b = 255; end
        4: begin d.r = l;   d.g = 0;   d.b = 255; end
        default: begin d.r = 255; d.g = 0; d.b = dn; end
      endcase
    end
    return d;
  endfunction

  // Monitor: accumulates each 256-clock window and checks it on completion.
  initial begin
    int    edge_n;
    int    hi[3];
    bit    seen0[3];
    bit    gap[3];
    duty_t e;
    edge_n = 0;
    for (int c = 0; c < 3; c++) begin hi[c] = 0; seen0[c] = 0; gap[c] = 0; end
    forever begin
      @(posedge clk);
      #1;
      if (!mon_en) begin
        edge_n = 0;
        for (int c = 0; c < 3; c++) begin hi[c] = 0; seen0[c] = 0; gap[c] = 0; end
      end else begin
        for (int c = 0; c < 3; c++) begin
          if (rgb[c]) begin
            hi[c]++;
            if (seen0[c]) gap[c] = 1'b1;
          end else begin
            seen0[c] = 1'b1;
          end
        end
        edge_n++;
        if (edge_n % 256 == 0) begin
          if (exp_q.size() == 0) begin
            check("sb_underflow", 0, 1);
          end else begin
            e = exp_q.pop_front();
            check("red_high",   hi[2], e.r);
            check("green_high", hi[1], e.g);
            check("blue_high",  hi[0], e.b);
            check("contiguous_gaps", int'(gap[2]) + int'(gap[1]) + int'(gap[0]), 0);
          end
          for (int c = 0; c < 3; c++) begin hi[c] = 0; seen0[c] = 0; gap[c] = 0; end
        end
      end
    end
  end

  // Stimulus
  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (1000) @(posedge clk);

    // Asynchronous assertion between edges must clear rgb immediately.
    @(negedge clk);
    #1 reset = 1'b0;
    #1 check("async_reset_rgb", int'(rgb), 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 check("reset_hold_rgb", int'(rgb), 0);
    end

    for (int m = 0; m < c_nper; m++) exp_q.push_back(model(m));

    @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;
    repeat (c_nper * 256) @(posedge clk);
    #2;
    mon_en = 1'b0;
    check("sb_leftover", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
